// File: rtl/iob_wishbone2iob_pkg.sv
// Shared definitions for the Wishbone-to-IOb bridge: 3-bit state encoding.
`default_nettype none

package iob_wishbone2iob_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/iob_wishbone2iob_timer.sv
// iob_wb2iob_timer: free-running TIMEOUT_W counter with clear/enable and an expiry flag.
// Used by iob_wishbone2iob only when IOB_WB2IOB_TIMEOUT_EN is defined.
`default_nettype none

module iob_wb2iob_timer #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // Expiry is flagged one count early so the registered error lands on
  // cycle 2**TIMEOUT_W-1 after the request pulse.
  localparam logic [TIMEOUT_W-1:0] LAST = ~TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (enable_i) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired_o = enable_i && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/iob_wishbone2iob.sv
// iob_wishbone2iob: Wishbone B4 classic slave to IOb native master, one transfer at a time.
// Optional access timeout enabled by defining IOB_WB2IOB_TIMEOUT_EN.
`default_nettype none

module iob_wishbone2iob
  import iob_wishbone2iob_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W/8-1:0] wb_select_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                wb_ack_o,
  output logic                wb_error_o,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i
);

  state_t            state;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              timeout;

`ifdef IOB_WB2IOB_TIMEOUT_EN
  // Held clear while idle, so the count equals cycles elapsed since valid_o.
  iob_wb2iob_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) timer (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .clear_i   (state == ST_IDLE),
    .enable_i  ((state == ST_REQ) || (state == ST_WAIT) || (state == ST_DRAIN)),
    .expired_o (timeout)
  );
`else
  logic [TIMEOUT_W-1:0] unused_timeout_w;
  assign unused_timeout_w = '0;
  assign timeout          = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      address_o  <= '0;
      wdata_o    <= '0;
      wstrb_o    <= '0;
      valid_o    <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_error_o <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_error_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            address_o <= wb_addr_i;
            wdata_o   <= wb_data_i;
            wstrb_o   <= wb_we_i ? wb_select_i : '0;
            we_q      <= wb_we_i;
            valid_o   <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT: begin
          // An aborted cycle must still let the IOb access finish before idling.
          if (!wb_cyc_i) begin
            state <= (ready_i || timeout) ? ST_IDLE : ST_DRAIN;
          end else if (ready_i) begin
            rdata_q  <= we_q ? '0 : rdata_i;
            wb_ack_o <= 1'b1;
            state    <= ST_RESP;
          end else if (timeout) begin
            rdata_q    <= '0;
            wb_error_o <= 1'b1;
            state      <= ST_ERR;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (ready_i || timeout) state <= ST_IDLE;
        end
        ST_RESP, ST_ERR: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wb_data_o = (state == ST_RESP) ? rdata_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_iob_wishbone2iob.sv
// Scoreboard bench for iob_wishbone2iob: directed Wishbone transfers against a scripted IOb slave.
`default_nettype none

module tb_iob_wishbone2iob;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic [AW-1:0] wb_addr = '0;
  logic [3:0]    wb_sel = '0;
  logic          wb_we = 1'b0;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic [DW-1:0] wb_wdata = '0;
  logic [DW-1:0] wb_data_o;
  logic          wb_ack_o;
  logic          wb_error_o;
  logic          valid_o;
  logic [AW-1:0] address_o;
  logic [DW-1:0] wdata_o;
  logic [3:0]    wstrb_o;
  logic [DW-1:0] rdata = '0;
  logic          ready = 1'b0;

  iob_wishbone2iob #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .wb_addr_i(wb_addr), .wb_select_i(wb_sel), .wb_we_i(wb_we),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_data_i(wb_wdata),
    .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o), .wb_error_o(wb_error_o),
    .valid_o(valid_o), .address_o(address_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .rdata_i(rdata), .ready_i(ready)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
  } iob_t;

  typedef struct {
    bit            err;
    logic [DW-1:0] data;
  } resp_t;

  iob_t  iob_q[$];
  resp_t resp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every ack/error must match the oldest expected response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (arst_n && (wb_ack_o || wb_error_o)) begin
        check("ack_err_exclusive", 64'(wb_ack_o & wb_error_o), 64'd0);
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: ack=%b err=%b expected none", wb_ack_o, wb_error_o);
        end else begin
          r = resp_q.pop_front();
          check("resp_is_error", 64'(wb_error_o), 64'(r.err));
          check("resp_data", 64'(wb_data_o), 64'(r.data));
        end
      end
    end
  end

  // IOb request monitor.
  initial begin
    iob_t e;
    bit   prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (arst_n && valid_o) begin
        check("valid_single_pulse", 64'(prev_valid), 64'd0);
        if (iob_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: addr=%0h expected none", address_o);
        end else begin
          e = iob_q.pop_front();
          check("iob_address", 64'(address_o), 64'(e.addr));
          check("iob_wdata", 64'(wdata_o), 64'(e.wdata));
          check("iob_wstrb", 64'(wstrb_o), 64'(e.wstrb));
        end
      end
      prev_valid = arst_n && valid_o;
    end
  end

  task automatic push_iob(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] s);
    iob_t e;
    e.addr  = a;
    e.wdata = d;
    e.wstrb = we ? s : 4'h0;
    iob_q.push_back(e);
  endtask

  task automatic push_resp(input bit err, input logic [DW-1:0] d);
    resp_t r;
    r.err  = err;
    r.data = d;
    resp_q.push_back(r);
  endtask

  task automatic start_wb(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] s);
    @(posedge clk);
    #1;
    wb_we = we; wb_addr = a; wb_wdata = d; wb_sel = s;
    wb_cyc = 1'b1; wb_stb = 1'b1;
  endtask

  task automatic end_wb();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wait_valid(output int vc, output bit ok);
    ok = 1'b0;
    vc = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (valid_o) begin
        ok = 1'b1;
        vc = cycle;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid_o expected valid_o within 20 cycles");
    end
  endtask

  // Full transfer; the IOb slave answers d cycles after valid_o.
  task automatic wb_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s, input logic [DW-1:0] rd, input int dly);
    int c0, vc;
    bit ok;
    push_iob(we, a, d, s);
    push_resp(1'b0, we ? 32'h0 : rd);
    start_wb(we, a, d, s);
    c0 = cycle;
    wait_valid(vc, ok);
    if (ok) begin
      check("valid_latency", 64'(vc - c0), 64'd1);
      if (dly > 0) begin
        repeat (dly) @(posedge clk);
        #1;
      end
      rdata = rd;
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      rdata = 32'h5A5A_0000 ^ rdata;
      @(negedge clk);
      check("ack_after_ready", 64'(wb_ack_o), 64'd1);
      check("stb_to_ack_latency", 64'(cycle - c0), 64'(dly + 2));
      @(posedge clk);
      #1;
      end_wb();
      @(negedge clk);
      check("ack_one_cycle", 64'(wb_ack_o), 64'd0);
    end else begin
      end_wb();
      resp_q.delete();
    end
  endtask

  initial begin
    int vc, acks;
    bit ok;

    #1 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({valid_o, wb_ack_o, wb_error_o}), 64'd0);
    check("rst_addr", 64'(address_o), 64'd0);
    check("rst_wdata_wstrb", 64'({wdata_o, wstrb_o}), 64'd0);
    check("rst_rdata", 64'(wb_data_o), 64'd0);
    arst_n = 1'b1;

    // Write with slave two cycles late, then a zero-wait read.
    wb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2);
    wb_xfer(1'b0, 32'h20, 32'h0, 4'hF, 32'h12345678, 0);

    // Byte-lane write, and a read whose select must not reach wstrb.
    wb_xfer(1'b1, 32'h30, 32'hA5A5A5A5, 4'h4, 32'h0, 1);
    wb_xfer(1'b0, 32'h34, 32'h11112222, 4'h4, 32'hCAFEF00D, 1);

    // Abort in WAIT: access drains silently, next request served normally.
    push_iob(1'b1, 32'h40, 32'h0BADF00D, 4'h3);
    start_wb(1'b1, 32'h40, 32'h0BADF00D, 4'h3);
    wait_valid(vc, ok);
    @(posedge clk);
    #1;
    end_wb();
    repeat (3) @(posedge clk);
    #1;
    rdata = 32'hFFFF0000;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    check("abort_no_ack", 64'(acks), 64'd0);
    wb_xfer(1'b0, 32'h44, 32'h0, 4'hF, 32'h600DCAFE, 1);

`ifdef IOB_WB2IOB_TIMEOUT_EN
    // Timeout: no ready at all, error after 15 cycles, late ready ignored.
    push_iob(1'b0, 32'h50, 32'h0, 4'hF);
    push_resp(1'b1, 32'h0);
    start_wb(1'b0, 32'h50, 32'h0, 4'hF);
    wait_valid(vc, ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (wb_error_o) begin
        ok = 1'b1;
        check("timeout_latency", 64'(cycle - vc), 64'd15);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout_missing: got no wb_error_o expected one within 40 cycles");
      resp_q.delete();
    end
    @(posedge clk);
    #1;
    end_wb();
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_ack_o || wb_error_o) acks++;
    end
    check("late_ready_ignored", 64'(acks), 64'd0);
`endif

    // Asynchronous reset during WAIT.
    push_iob(1'b0, 32'h60, 32'h0, 4'hF);
    start_wb(1'b0, 32'h60, 32'h0, 4'hF);
    wait_valid(vc, ok);
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    check("arst_ctrl", 64'({valid_o, wb_ack_o, wb_error_o}), 64'd0);
    check("arst_addr", 64'(address_o), 64'd0);
    check("arst_wdata_wstrb", 64'({wdata_o, wstrb_o}), 64'd0);
    check("arst_rdata", 64'(wb_data_o), 64'd0);
    end_wb();
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    wb_xfer(1'b0, 32'h64, 32'h0, 4'hF, 32'h87654321, 1);

    repeat (4) @(posedge clk);
    check("iob_queue_empty", 64'(iob_q.size()), 64'd0);
    check("resp_queue_empty", 64'(resp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1);
  end

endmodule

`default_nettype wire
